// File: rtl/dft_bin_correlator.sv
// Per-bin correlator for a two-channel single-bin DFT: auto-powers and cross-product,
// integrated over a runtime-programmable number of frames at full precision.
//
// state  | meaning
// S_IDLE | no integration open; next product starts one and latches the length
// S_ACC  | integration open; products are summed until the latched length is reached
module dft_bin_correlator #(
    parameter int DIN_WIDTH     = 32,
    parameter int DIN_POINT     = 15,
    parameter int ACC_LEN_WIDTH = 16,
    localparam int PROD_WIDTH   = 2*DIN_WIDTH+1,
    localparam int ACC_WIDTH    = PROD_WIDTH+ACC_LEN_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2*DIN_WIDTH-1:0]     din_re,
    input  logic [2*DIN_WIDTH-1:0]     din_im,
    input  logic                       din_valid,
    input  logic [ACC_LEN_WIDTH-1:0]   acc_len,
    output logic [ACC_WIDTH-1:0]       pow0,
    output logic [ACC_WIDTH-1:0]       pow1,
    output logic [ACC_WIDTH-1:0]       corr_re,
    output logic [ACC_WIDTH-1:0]       corr_im,
    output logic                       dout_valid,
    output logic [ACC_LEN_WIDTH-1:0]   frame_count
);

    localparam int                     PW2     = 2*DIN_WIDTH;
    localparam logic [ACC_LEN_WIDTH-1:0] LEN_ONE = {{(ACC_LEN_WIDTH-1){1'b0}}, 1'b1};

    // Output binary point sits at 2*DIN_POINT; fractional bits must fit the sample.
    if (DIN_POINT >= DIN_WIDTH) begin : g_bad_point
        $error("dft_bin_correlator: DIN_POINT must be smaller than DIN_WIDTH");
    end

    typedef enum logic {S_IDLE, S_ACC} state_t;

    function automatic logic [PROD_WIDTH-1:0] sx_prod(input logic [PW2-1:0] v);
        return {v[PW2-1], v};
    endfunction

    function automatic logic [ACC_WIDTH-1:0] sx_acc(input logic [PROD_WIDTH-1:0] v);
        return {{ACC_LEN_WIDTH{v[PROD_WIDTH-1]}}, v};
    endfunction

    // Stage 1: input register
    logic [PW2-1:0] re_q, im_q;
    logic           v1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            re_q <= '0;
            im_q <= '0;
            v1_q <= 1'b0;
        end else begin
            re_q <= din_re;
            im_q <= din_im;
            v1_q <= din_valid;
        end
    end

    // Stage 2: the eight partial products
    logic signed [DIN_WIDTH-1:0] ar, ai, br, bi;
    assign ar = re_q[DIN_WIDTH-1:0];
    assign br = re_q[PW2-1:DIN_WIDTH];
    assign ai = im_q[DIN_WIDTH-1:0];
    assign bi = im_q[PW2-1:DIN_WIDTH];

    logic signed [PW2-1:0] arar_q, aiai_q, brbr_q, bibi_q, arbr_q, aibi_q, aibr_q, arbi_q;
    logic                  v2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            arar_q <= '0; aiai_q <= '0; brbr_q <= '0; bibi_q <= '0;
            arbr_q <= '0; aibi_q <= '0; aibr_q <= '0; arbi_q <= '0;
            v2_q   <= 1'b0;
        end else begin
            arar_q <= ar * ar; aiai_q <= ai * ai;
            brbr_q <= br * br; bibi_q <= bi * bi;
            arbr_q <= ar * br; aibi_q <= ai * bi;
            aibr_q <= ai * br; arbi_q <= ar * bi;
            v2_q   <= v1_q;
        end
    end

    // Stage 3: combine at PROD_WIDTH
    logic [PROD_WIDTH-1:0] p0_q, p1_q, cr_q, ci_q;
    logic                  v3_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            p0_q <= '0; p1_q <= '0; cr_q <= '0; ci_q <= '0;
            v3_q <= 1'b0;
        end else begin
            p0_q <= sx_prod(arar_q) + sx_prod(aiai_q);
            p1_q <= sx_prod(brbr_q) + sx_prod(bibi_q);
            cr_q <= sx_prod(arbr_q) + sx_prod(aibi_q);
            ci_q <= sx_prod(aibr_q) - sx_prod(arbi_q);
            v3_q <= v2_q;
        end
    end

    // Stage 4: integration FSM
    state_t                   state_q, state_d;
    logic [ACC_LEN_WIDTH-1:0] cnt_q, cnt_d, len_q, len_d, len_new;
    logic [ACC_WIDTH-1:0]     acc0_q, acc1_q, accr_q, acci_q;
    logic [ACC_WIDTH-1:0]     acc0_d, acc1_d, accr_d, acci_d;
    logic [ACC_WIDTH-1:0]     out0_q, out1_q, outr_q, outi_q;
    logic [ACC_WIDTH-1:0]     out0_d, out1_d, outr_d, outi_d;
    logic [ACC_WIDTH-1:0]     e0, e1, er, ei;
    logic                     dv_q, dv_d;

    assign e0      = sx_acc(p0_q);
    assign e1      = sx_acc(p1_q);
    assign er      = sx_acc(cr_q);
    assign ei      = sx_acc(ci_q);
    assign len_new = (acc_len == '0) ? LEN_ONE : acc_len;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= LEN_ONE;
            acc0_q  <= '0; acc1_q <= '0; accr_q <= '0; acci_q <= '0;
            out0_q  <= '0; out1_q <= '0; outr_q <= '0; outi_q <= '0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            acc0_q  <= acc0_d; acc1_q <= acc1_d; accr_q <= accr_d; acci_q <= acci_d;
            out0_q  <= out0_d; out1_q <= out1_d; outr_q <= outr_d; outi_q <= outi_d;
            dv_q    <= dv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        acc0_d  = acc0_q; acc1_d = acc1_q; accr_d = accr_q; acci_d = acci_q;
        out0_d  = out0_q; out1_d = out1_q; outr_d = outr_q; outi_d = outi_q;
        dv_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (v3_q) begin
                    len_d  = len_new;
                    acc0_d = e0; acc1_d = e1; accr_d = er; acci_d = ei;
                    if (len_new == LEN_ONE) begin
                        // single-frame integration: load and dump together, no gap
                        out0_d = e0; out1_d = e1; outr_d = er; outi_d = ei;
                        dv_d   = 1'b1;
                    end else begin
                        cnt_d   = LEN_ONE;
                        state_d = S_ACC;
                    end
                end
            end
            S_ACC: begin
                if (v3_q) begin
                    if (cnt_q + LEN_ONE == len_q) begin
                        out0_d  = acc0_q + e0; out1_d = acc1_q + e1;
                        outr_d  = accr_q + er; outi_d = acci_q + ei;
                        dv_d    = 1'b1;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        acc0_d = acc0_q + e0; acc1_d = acc1_q + e1;
                        accr_d = accr_q + er; acci_d = acci_q + ei;
                        cnt_d  = cnt_q + LEN_ONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign pow0        = out0_q;
    assign pow1        = out1_q;
    assign corr_re     = outr_q;
    assign corr_im     = outi_q;
    assign dout_valid  = dv_q;
    assign frame_count = cnt_q;

endmodule
